d_branch_seq: RTL

D_BRANCH_SEQ -- requirements
Module: d_branch_seq

---
 rtl/d_branch_seq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/d_branch_seq.sv
// D-stage branch sequencer: holds a branch in D until its comparator operands are forwardable, then fires the compare.
// Optional statistics counters are built only when D_BRANCH_SEQ_STATS_EN is defined.
module d_branch_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        D_valid,
  input  logic        D_branch,
  input  logic        D_link,
  input  logic        D_use_rt,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [4:0]  E_wr_addr,
  input  logic [4:0]  M_wr_addr,
  input  logic [1:0]  E_tnew,
  input  logic [1:0]  M_tnew,
  input  logic        D_flush,
  input  logic        cmp_pcsrc,
  output logic        cmp_en,
  output logic        stall,
  output logic        npc_sel,
  output logic        link_we,
  output logic [1:0]  wait_cnt,
  output logic [15:0] stat_taken,
  output logic [15:0] stat_stall
);

  typedef enum logic [1:0] {IDLE, WAIT, CMP} state_e;

  state_e     state_q, state_d;
  logic [1:0] wait_cnt_q, wait_cnt_d;
  logic       rsHazard, rtHazard, hazard, branchReq;

  // A source is hazardous when a pending writer in E or M targets it and its result is not yet forwardable.
  always_comb begin
    rsHazard = (D_rs_addr != 5'd0) &
               (((D_rs_addr == E_wr_addr) & (E_tnew != 2'd0)) |
                ((D_rs_addr == M_wr_addr) & (M_tnew != 2'd0)));
    rtHazard = (D_rt_addr != 5'd0) &
               (((D_rt_addr == E_wr_addr) & (E_tnew != 2'd0)) |
                ((D_rt_addr == M_wr_addr) & (M_tnew != 2'd0)));
    hazard    = rsHazard | (D_use_rt & rtHazard);
    branchReq = D_valid & D_branch & ~D_flush;
  end

  // Outputs are decoded from the current state; reset and flush silence them in the same cycle.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    stall      = 1'b0;
    cmp_en     = 1'b0;
    npc_sel    = 1'b0;
    link_we    = 1'b0;
    if (reset) begin
      state_d    = IDLE;
      wait_cnt_d = 2'd0;
    end else if (D_flush) begin
      state_d    = IDLE;
      wait_cnt_d = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          stall = branchReq;
          if (branchReq) begin
            state_d    = hazard ? WAIT : CMP;
            wait_cnt_d = hazard ? 2'd1 : 2'd0;
          end
        end
        WAIT: begin
          stall = 1'b1;
          if (hazard) begin
            wait_cnt_d = (wait_cnt_q == 2'd3) ? 2'd3 : wait_cnt_q + 2'd1;
          end else begin
            state_d    = CMP;
            wait_cnt_d = 2'd0;
          end
        end
        CMP: begin
          cmp_en     = 1'b1;
          npc_sel    = cmp_pcsrc;
          link_we    = D_link;
          state_d    = IDLE;
          wait_cnt_d = 2'd0;
        end
        default: begin
          state_d    = IDLE;
          wait_cnt_d = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign wait_cnt = wait_cnt_q;

`ifdef D_BRANCH_SEQ_STATS_EN
  logic [15:0] stat_taken_q, stat_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_taken_q <= 16'd0;
      stat_stall_q <= 16'd0;
    end else begin
      if (cmp_en && npc_sel && (stat_taken_q != 16'hFFFF)) stat_taken_q <= stat_taken_q + 16'd1;
      if (stall && (stat_stall_q != 16'hFFFF)) stat_stall_q <= stat_stall_q + 16'd1;
    end
  end

  assign stat_taken = stat_taken_q;
  assign stat_stall = stat_stall_q;
`else
  assign stat_taken = 16'd0;
  assign stat_stall = 16'd0;
`endif

endmodule
